mdu_iter: RTL
=============

Name: mdu_iter

Overview:
Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. It takes the same rs1/rs2 operands (A, B) that feed the ALU. Its result joins the ALU C output at the writeback mux. While an operation runs, busy stalls the pipeline; done marks the cycle in which C is valid.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITER, 32, shift-add / restoring-divide iterations per operation

Ports:
cpu_clk  input  1  clock, all state updates on rising edge
cpu_rst  input  1  synchronous, active-high reset
start    input  1  request; sampled only in IDLE or DONE
op       input  3  RV32M funct3: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111
A        input  32  rs1 operand, sampled with start
B        input  32  rs2 operand, sampled with start
busy     output 1  high while state==RUN; pipeline stall request
done     output 1  one-cycle pulse, high while state==DONE
C        output 32  result register; valid from the done cycle and held until the next accepted start

Behaviour:
- Reset (cpu_rst=1 at an edge): state=IDLE, busy=0, done=0, C=0, counter=0. Applies in any state, including mid-RUN; the operation in flight is discarded.
- States and transitions:
  - IDLE: start → RUN. Fast path: divide op with B==0, or signed DIV/REM with A=0x80000000 and B=0xFFFFFFFF → DONE directly.
  - RUN: 32 iterations, counter 0..31; counter==31 → DONE.
  - DONE: start → RUN (or DONE via fast path); otherwise → IDLE.
- start while in RUN is ignored; op, A and B are not resampled.
- Latency, with start sampled in cycle 0:
  - Normal: busy=1 in cycles 1..32, done=1 in cycle 33.
  - Fast path: done=1 in cycle 1 and busy never rises.
- Operands latched at acceptance: op, sign flags, |A|, |B|.
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply: radix-2 shift-add on magnitudes into a 64-bit accumulator. The product is negated if the sign flags differ. MUL returns P[31:0]; MULH/MULHSU/MULHU return P[63:32].
- Divide: restoring division on magnitudes, 33-bit partial remainder, one quotient bit per cycle.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the sign of A.
- Special results (RISC-V spec, no trap):
  - Divide by zero: quotient 0xFFFFFFFF; remainder = A.
  - Signed overflow: quotient 0x80000000; remainder 0.
- C is written once, on the transition into DONE, and is stable otherwise.
- busy and done are decoded from registered state only; there is no combinational path from start to busy.

Decomposition:
- defines.vh gains:
  - MDU_MUL..MDU_REMU funct3 constants, 3 bits, alongside the ALU_* opcodes.
  - MDU_IDLE/MDU_RUN/MDU_DONE state encodings, 2 bits.
- Single module. Multiply and divide share the 64-bit datapath register and the counter; no sub-module is warranted.

Test Plan:
- MUL A=7, B=0xFFFFFFFD → busy cycles 1..32, done cycle 33, C=0xFFFFFFEB.
- MULH high-half cases, each → done cycle 33:
  - MULH 0x80000000×0x80000000 → C=0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → C=0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → C=0xFFFFFFFF.
- Division, each → done cycle 33:
  - DIV 0xFFFFFFF9/2 → C=0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 → C=0xFFFFFFFF.
  - DIVU 100/7 → C=14.
  - REMU 100/7 → C=2.
- Fast path, each → done cycle 1, busy never 1:
  - DIV 5/0 → C=0xFFFFFFFF.
  - REM 5/0 → C=5.
  - DIV 0x80000000/0xFFFFFFFF → C=0x80000000.
  - REM of the same operands → C=0.
- Start during RUN (cycle 5, different op/A/B) → ignored; original result delivered at cycle 33. Then cpu_rst=1 in cycle 10 of a new op → cycle 11 busy=0, done=0, C=0, state IDLE.
- Back-to-back: MUL 3×4 done at cycle 33 with start=1 for DIVU 9/2 in that cycle → C=12 held through cycles 34..65, busy cycles 34..65, done cycle 66 with C=4.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM states and operand-signedness helpers.
package mdu_iter_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_signed_a(input mdu_op_e o);
        return !(o inside {MDU_MULHU, MDU_DIVU, MDU_REMU});
    endfunction

    function automatic logic op_signed_b(input mdu_op_e o);
        return o inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_is_div(input mdu_op_e o);
        return o inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

    function automatic logic op_is_rem(input mdu_op_e o);
        return o inside {MDU_REM, MDU_REMU};
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, shared 64-bit register.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] C
);

    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] XONES = {XLEN{1'b1}};

    mdu_state_e        state_reg, state_next;
    mdu_op_e           op_reg, op_next;
    logic              neg_q_reg, neg_q_next;
    logic              neg_r_reg, neg_r_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   b_reg, b_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [XLEN-1:0]   c_reg, c_next;

    // Acceptance-time decode of the incoming request
    mdu_op_e         op_in;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_zero_in, div_ovf_in, fast_in;
    logic [XLEN-1:0] fast_res_in;

    assign op_in       = mdu_op_e'(op);
    assign sa_in       = op_signed_a(op_in) & A[XLEN-1];
    assign sb_in       = op_signed_b(op_in) & B[XLEN-1];
    assign a_mag_in    = sa_in ? -A : A;
    assign b_mag_in    = sb_in ? -B : B;
    assign div_zero_in = op_is_div(op_in) && (B == '0);
    assign div_ovf_in  = (op_in inside {MDU_DIV, MDU_REM}) && (A == XMIN) && (B == XONES);
    assign fast_in     = div_zero_in || div_ovf_in;

    always_comb begin
        if (div_zero_in)
            fast_res_in = op_is_rem(op_in) ? A : XONES;
        else
            fast_res_in = op_is_rem(op_in) ? '0 : XMIN;
    end

    // One multiply step: conditionally add |B| to the high half, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, (acc_reg[0] ? b_reg : '0)};
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // One restoring-divide step: high half is the remainder, low half shifts
    // out dividend bits and shifts in quotient bits
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_step;
    assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, b_reg};
    assign div_rem   = div_ge ? XLEN'(div_shift - {1'b0, b_reg}) : div_shift[XLEN-1:0];
    assign div_step  = {div_rem, acc_reg[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] iter_next, prod_fin;
    logic [XLEN-1:0]   quo, rem, final_res;
    assign iter_next = op_is_div(op_reg) ? div_step : mul_step;
    assign prod_fin  = neg_q_reg ? -iter_next : iter_next;
    assign quo       = iter_next[XLEN-1:0];
    assign rem       = iter_next[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        case (op_reg)
            MDU_MUL:                        final_res = prod_fin[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod_fin[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              final_res = neg_q_reg ? -quo : quo;
            default:                        final_res = neg_r_reg ? -rem : rem;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        acc_next   = acc_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        c_next     = c_reg;
        case (state_reg)
            MDU_IDLE, MDU_DONE: begin
                if (start) begin
                    op_next    = op_in;
                    neg_q_next = sa_in ^ sb_in;
                    neg_r_next = sa_in;
                    if (fast_in) begin
                        state_next = MDU_DONE;
                        c_next     = fast_res_in;
                    end else begin
                        state_next = MDU_RUN;
                        acc_next   = {{XLEN{1'b0}}, a_mag_in};
                        b_next     = b_mag_in;
                        cnt_next   = '0;
                    end
                end else if (state_reg == MDU_DONE) begin
                    state_next = MDU_IDLE;
                end
            end
            MDU_RUN: begin
                acc_next = iter_next;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(ITER - 1)) begin
                    state_next = MDU_DONE;
                    c_next     = final_res;
                end
            end
            default: state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_reg <= MDU_IDLE;
            op_reg    <= MDU_MUL;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            acc_reg   <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            c_reg     <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
            acc_reg   <= acc_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            c_reg     <= c_next;
        end
    end

    assign busy = (state_reg == MDU_RUN);
    assign done = (state_reg == MDU_DONE);
    assign C    = c_reg;

endmodule
